mem_xfer_unit: RTL and testbench

Memory-stage datapath controller that sits directly downstream of the stage FSM. It captures the EXST-stage memory request on `exst_wen`, performs one data-memory word transfer in each MEM cycle, and sequences single and multiple-register (load/store-multiple) transfers. For multi-register operations it raises `mem_force` so the stage FSM loops MEM→EXST→MEM until every register in the list has been transferred.

---
 rtl/mem_xfer_unit.sv | 110 +++++++++++
 tb/tb_mem_xfer_unit.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/mem_xfer_unit.sv
// rtl/mem_xfer_unit.sv - memory-stage transfer controller for single and multiple-register load/store
// Captures the EXST request once, then performs one word transfer per MEM cycle.
module mem_xfer_unit (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_exst_wen,
   input  logic        i_mem_stage,
   input  logic        i_ex_load,
   input  logic        i_ex_multi,
   input  logic [31:0] i_ex_addr,
   input  logic [3:0]  i_ex_rd,
   input  logic [31:0] i_ex_store_data,
   input  logic [15:0] i_ex_reglist,
   input  logic [31:0] i_rf_rdata,
   input  logic [31:0] i_dmem_rdata,
   output logic        o_mem_force,
   output logic        o_dmem_en,
   output logic        o_dmem_we,
   output logic [31:0] o_dmem_addr,
   output logic [31:0] o_dmem_wdata,
   output logic [3:0]  o_rf_raddr,
   output logic        o_rf_we,
   output logic [3:0]  o_rf_waddr,
   output logic [31:0] o_rf_wdata,
   output logic [31:0] o_final_addr
);

   logic        r_busy;
   logic        r_load_q;
   logic        r_multi_q;
   logic [29:0] r_addr_q;
   logic [15:0] r_list_q;
   logic [3:0]  r_rd_q;
   logic [31:0] r_sdata_q;

   logic [3:0]  w_cur_idx;
   logic [15:0] w_list_rest;
   logic        w_last;
   logic        w_dmem_en;
   logic        w_mem_force;
   logic        w_unused;

   assign w_unused    = &{1'b0, i_ex_addr[1:0]};
   // Clearing the lowest set bit leaves the registers still to transfer.
   assign w_list_rest = r_list_q & (r_list_q - 16'd1);
   assign w_last      = (w_list_rest == 16'd0);
   assign w_dmem_en   = ~r_multi_q | (r_list_q != 16'd0);
   assign w_mem_force = r_multi_q & ~w_last;

   always_comb begin
      w_cur_idx = 4'd0;
      for (int i = 15; i >= 0; i--) begin
         if (r_list_q[i]) begin
            w_cur_idx = 4'(i);
         end
      end
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_busy    <= 1'b0;
         r_load_q  <= 1'b0;
         r_multi_q <= 1'b0;
         r_addr_q  <= '0;
         r_list_q  <= '0;
         r_rd_q    <= '0;
         r_sdata_q <= '0;
      end else if (i_mem_stage) begin
         if (r_multi_q) begin
            r_list_q <= w_list_rest;
            r_addr_q <= r_addr_q + 30'd1;
            r_busy   <= w_mem_force;
         end else begin
            r_busy   <= 1'b0;
         end
      end else if (i_exst_wen && !r_busy) begin
         r_busy    <= 1'b1;
         r_load_q  <= i_ex_load;
         r_multi_q <= i_ex_multi;
         r_addr_q  <= i_ex_addr[31:2];
         r_list_q  <= i_ex_reglist;
         r_rd_q    <= i_ex_rd;
         r_sdata_q <= i_ex_store_data;
      end
   end

   always_comb begin
      o_mem_force  = 1'b0;
      o_dmem_en    = 1'b0;
      o_dmem_we    = 1'b0;
      o_dmem_addr  = '0;
      o_dmem_wdata = '0;
      o_rf_we      = 1'b0;
      o_rf_waddr   = '0;
      o_rf_wdata   = '0;
      o_rf_raddr   = w_cur_idx;
      o_final_addr = {r_addr_q, 2'b00};
      if (i_mem_stage) begin
         o_mem_force  = w_mem_force;
         o_dmem_en    = w_dmem_en;
         o_dmem_we    = w_dmem_en & ~r_load_q;
         o_dmem_addr  = {r_addr_q, 2'b00};
         o_dmem_wdata = r_multi_q ? i_rf_rdata : r_sdata_q;
         o_rf_we      = w_dmem_en & r_load_q;
         o_rf_waddr   = r_multi_q ? w_cur_idx : r_rd_q;
         o_rf_wdata   = i_dmem_rdata;
      end
   end

endmodule

// File: tb/tb_mem_xfer_unit.sv
// tb/tb_mem_xfer_unit.sv - self-checking bench for mem_xfer_unit
// A transfer-queue model predicts every output each cycle; directed checks pin known values.
module tb_mem_xfer_unit;

   logic        clk = 1'b0;
   logic        i_reset = 1'b1;
   logic        i_exst_wen = 1'b0;
   logic        i_mem_stage = 1'b0;
   logic        i_ex_load = 1'b0;
   logic        i_ex_multi = 1'b0;
   logic [31:0] i_ex_addr = '0;
   logic [3:0]  i_ex_rd = '0;
   logic [31:0] i_ex_store_data = '0;
   logic [15:0] i_ex_reglist = '0;
   logic [31:0] i_rf_rdata;
   logic [31:0] i_dmem_rdata;
   logic        o_mem_force, o_dmem_en, o_dmem_we, o_rf_we;
   logic [31:0] o_dmem_addr, o_dmem_wdata, o_rf_wdata, o_final_addr;
   logic [3:0]  o_rf_raddr, o_rf_waddr;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   function automatic logic [31:0] rf_val(input logic [3:0] idx);
      return {24'hC0FFEE, 4'h0, idx};
   endfunction

   function automatic logic [31:0] mem_val(input logic [31:0] a);
      return (a == 32'h100) ? 32'hDEADBEEF : ~a;
   endfunction

   assign i_rf_rdata   = rf_val(o_rf_raddr);
   assign i_dmem_rdata = mem_val(o_dmem_addr);

   mem_xfer_unit dut (
      .i_clk(clk), .i_reset(i_reset), .i_exst_wen(i_exst_wen), .i_mem_stage(i_mem_stage),
      .i_ex_load(i_ex_load), .i_ex_multi(i_ex_multi), .i_ex_addr(i_ex_addr), .i_ex_rd(i_ex_rd),
      .i_ex_store_data(i_ex_store_data), .i_ex_reglist(i_ex_reglist), .i_rf_rdata(i_rf_rdata),
      .i_dmem_rdata(i_dmem_rdata), .o_mem_force(o_mem_force), .o_dmem_en(o_dmem_en),
      .o_dmem_we(o_dmem_we), .o_dmem_addr(o_dmem_addr), .o_dmem_wdata(o_dmem_wdata),
      .o_rf_raddr(o_rf_raddr), .o_rf_we(o_rf_we), .o_rf_waddr(o_rf_waddr),
      .o_rf_wdata(o_rf_wdata), .o_final_addr(o_final_addr)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: pending register indices in transfer order, base address and count of MEM cycles done.
   logic        m_busy = 1'b0;
   logic        m_load = 1'b0;
   logic        m_multi = 1'b0;
   logic [31:0] m_base = '0;
   logic [31:0] m_done = '0;
   logic [3:0]  m_rd = '0;
   logic [31:0] m_sdata = '0;
   int          m_regs[$];

   initial forever begin
      @(posedge clk or posedge i_reset);
      if (i_reset) begin
         m_busy = 0; m_load = 0; m_multi = 0; m_base = 0; m_done = 0;
         m_rd = 0; m_sdata = 0; m_regs.delete();
      end else if (i_mem_stage) begin
         if (m_multi) begin
            if (m_regs.size() > 0) void'(m_regs.pop_front());
            m_done = m_done + 1;
            m_busy = (m_regs.size() > 0);
         end else begin
            m_busy = 0;
         end
      end else if (i_exst_wen && !m_busy) begin
         m_busy = 1; m_load = i_ex_load; m_multi = i_ex_multi;
         m_base = {i_ex_addr[31:2], 2'b00}; m_done = 0;
         m_rd = i_ex_rd; m_sdata = i_ex_store_data;
         m_regs.delete();
         for (int i = 0; i < 16; i++) if (i_ex_reglist[i]) m_regs.push_back(i);
      end
   end

   initial forever begin
      logic [3:0]  cur;
      logic [31:0] addr;
      logic        en, ms;
      @(negedge clk);
      #4;
      ms   = i_mem_stage;
      cur  = (m_regs.size() > 0) ? 4'(m_regs[0]) : 4'd0;
      addr = m_base + (m_done << 2);
      en   = ms && (!m_multi || m_regs.size() > 0);
      chk("mem_force",  o_mem_force,  ms && m_multi && m_regs.size() > 1);
      chk("dmem_en",    o_dmem_en,    en);
      chk("dmem_we",    o_dmem_we,    en && !m_load);
      chk("dmem_addr",  o_dmem_addr,  ms ? addr : 32'd0);
      chk("dmem_wdata", o_dmem_wdata, ms ? (m_multi ? rf_val(cur) : m_sdata) : 32'd0);
      chk("rf_raddr",   o_rf_raddr,   cur);
      chk("rf_we",      o_rf_we,      en && m_load);
      chk("rf_waddr",   o_rf_waddr,   ms ? (m_multi ? cur : m_rd) : 4'd0);
      chk("rf_wdata",   o_rf_wdata,   ms ? mem_val(addr) : 32'd0);
      chk("final_addr", o_final_addr, addr);
   end

   task automatic step(input logic exst, input logic ms);
      @(negedge clk);
      i_exst_wen  = exst;
      i_mem_stage = ms;
   endtask

   task automatic setup(input logic ld, input logic mu, input logic [31:0] a,
                        input logic [3:0] rd, input logic [31:0] sd, input logic [15:0] lst);
      i_ex_load = ld; i_ex_multi = mu; i_ex_addr = a;
      i_ex_rd = rd; i_ex_store_data = sd; i_ex_reglist = lst;
   endtask

   initial begin
      step(0, 0); step(0, 0);
      step(0, 0); i_reset = 0;
      #3 chk("rst_final", o_final_addr, 32'h0); chk("rst_raddr", o_rf_raddr, 4'd0);
      chk("rst_force", o_mem_force, 1'b0); chk("rst_en", o_dmem_en, 1'b0);

      step(1, 0); setup(1, 0, 32'h100, 4'd5, 32'h0, 16'h0);
      step(0, 1);
      #3 chk("ld_addr", o_dmem_addr, 32'h100); chk("ld_we", o_rf_we, 1'b1);
      chk("ld_waddr", o_rf_waddr, 4'd5); chk("ld_wdata", o_rf_wdata, 32'hDEADBEEF);
      chk("ld_force", o_mem_force, 1'b0);
      step(0, 0);

      step(1, 0); setup(0, 0, 32'h203, 4'd0, 32'h12345678, 16'h0);
      step(0, 1);
      #3 chk("st_addr", o_dmem_addr, 32'h200); chk("st_we", o_dmem_we, 1'b1);
      chk("st_wdata", o_dmem_wdata, 32'h12345678);
      step(0, 0);

      step(1, 0); setup(1, 1, 32'h40, 4'd0, 32'h0, 16'h0025);
      step(0, 1);
      #3 chk("ldm0_addr", o_dmem_addr, 32'h40); chk("ldm0_waddr", o_rf_waddr, 4'd0);
      chk("ldm0_force", o_mem_force, 1'b1);
      step(1, 0); setup(0, 0, 32'hDEAD0000, 4'd9, 32'h0, 16'hFFFF);
      step(0, 1);
      #3 chk("ldm1_addr", o_dmem_addr, 32'h44); chk("ldm1_waddr", o_rf_waddr, 4'd2);
      chk("ldm1_force", o_mem_force, 1'b1);
      step(1, 0);
      step(0, 1);
      #3 chk("ldm2_addr", o_dmem_addr, 32'h48); chk("ldm2_waddr", o_rf_waddr, 4'd5);
      chk("ldm2_force", o_mem_force, 1'b0);
      step(0, 0);
      #3 chk("ldm_final", o_final_addr, 32'h4C);

      step(1, 0); setup(0, 1, 32'hFFFFFFFC, 4'd0, 32'h0, 16'h8001);
      step(0, 1);
      #3 chk("stm0_raddr", o_rf_raddr, 4'd0); chk("stm0_addr", o_dmem_addr, 32'hFFFFFFFC);
      chk("stm0_wdata", o_dmem_wdata, 32'hC0FFEE00);
      step(1, 0);
      step(0, 1);
      #3 chk("stm1_raddr", o_rf_raddr, 4'd15); chk("stm1_addr", o_dmem_addr, 32'h0);
      chk("stm1_wdata", o_dmem_wdata, 32'hC0FFEE0F);
      step(0, 0);
      #3 chk("stm_final", o_final_addr, 32'h4);

      step(1, 0); setup(1, 1, 32'h80, 4'd0, 32'h0, 16'h0);
      step(0, 1);
      #3 chk("empty_en", o_dmem_en, 1'b0); chk("empty_we", o_rf_we, 1'b0);
      chk("empty_force", o_mem_force, 1'b0);
      step(1, 0); setup(1, 0, 32'h300, 4'd3, 32'h0, 16'h0);
      step(0, 1);
      #3 chk("after_empty_addr", o_dmem_addr, 32'h300); chk("after_empty_waddr", o_rf_waddr, 4'd3);
      step(0, 0);

      step(1, 0); setup(1, 1, 32'h500, 4'd0, 32'h0, 16'h0007);
      step(0, 1);
      step(1, 0);
      @(negedge clk); i_exst_wen = 0; i_mem_stage = 1;
      #1 chk("pre_rst_force", o_mem_force, 1'b1);
      #1 i_reset = 1; i_mem_stage = 0;
      #1 chk("rst_force_drop", o_mem_force, 1'b0); chk("rst_en_drop", o_dmem_en, 1'b0);
      step(0, 0);
      step(0, 0); i_reset = 0;
      step(1, 0); setup(1, 1, 32'h600, 4'd0, 32'h0, 16'h0003);
      step(0, 1);
      #3 chk("fresh0_addr", o_dmem_addr, 32'h600); chk("fresh0_force", o_mem_force, 1'b1);
      step(1, 0);
      step(0, 1);
      #3 chk("fresh1_addr", o_dmem_addr, 32'h604); chk("fresh1_waddr", o_rf_waddr, 4'd1);
      chk("fresh1_force", o_mem_force, 1'b0);
      step(0, 0);
      #3 chk("fresh_final", o_final_addr, 32'h608);
      step(0, 0);
      #3;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
